// File: rtl/filter2d_pkg.sv
// Shared types, kernel geometry and arithmetic helpers for the line-buffered 3x3 filter.
package filter2d_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_e;

  localparam int KSIZE = 3;
  localparam int NTAP  = KSIZE * KSIZE;
  localparam int IDX_W = 4;

  // Accumulator width: nine signed products plus sign and rounding headroom.
  function automatic int acc_w(input int pix_w, input int coef_w);
    return pix_w + coef_w + 5;
  endfunction

  function automatic logic [31:0] sat_pix(input logic signed [31:0] v, input int pix_w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< pix_w) - 32'sd1;
    if (v < 0) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/filter2d_lb_if.sv
// Single-port memory bus between the filter engine (master) and mem_single (slave).
interface filter2d_lb_if #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8
) ();
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  din;
  logic [PIX_W-1:0]  dout;

  modport master (output cs, we, addr, din, input dout);
  modport slave  (input cs, we, addr, din, output dout);
endinterface

// File: rtl/filter2d_mac.sv
// Combinational 3x3 multiply-accumulate with rounding shift, saturation and border copy.
module filter2d_mac
  import filter2d_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic [NTAP-1:0][PIX_W-1:0]  pix,
  input  logic [NTAP-1:0][COEF_W-1:0] coef,
  input  logic [NTAP-1:0]             valid,
  input  logic [3:0]                  shift,
  input  logic                        border_mode,
  output logic [PIX_W-1:0]            result
);

  localparam int ACC_W = acc_w(PIX_W, COEF_W);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shifted;

  // NOTE: blocking '=' here so the accumulator chains through the loop in one evaluation.
  always_comb begin
    acc = '0;
    for (int t = 0; t < NTAP; t++) begin
      if (valid[t]) acc = acc + ACC_W'($signed({1'b0, pix[t]})) * ACC_W'($signed(coef[t]));
    end
    rnd     = (shift == 4'd0) ? '0 : (ACC_W'(1) << (shift - 4'd1));
    shifted = (acc + rnd) >>> shift;
    if (border_mode && !(&valid)) result = pix[NTAP/2];
    else                          result = PIX_W'(sat_pix(32'(shifted), PIX_W));
  end

endmodule

// File: rtl/filter2d_lb.sv
// 3x3 image filter: reads each pixel once, keeps two line buffers, writes results back to one memory.
module filter2d_lb
  import filter2d_pkg::*;
#(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int PIX_W    = 8,
  parameter int COEF_W   = 8,
  parameter int ADDR_W   = 17,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = IMG_W * IMG_H
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                finish,
  output logic                busy,
  filter2d_lb_if.master       mem,
  input  logic                h_write,
  input  logic [IDX_W-1:0]    h_idx,
  input  logic [COEF_W-1:0]   h_data,
  input  logic [3:0]          shift,
  input  logic                border_mode
);

  localparam int RI_W = $clog2(IMG_H + 1);
  localparam int CI_W = $clog2(IMG_W + 1);
  localparam logic [RI_W-1:0] RI_LAST = RI_W'(IMG_H);
  localparam logic [CI_W-1:0] CI_LAST = CI_W'(IMG_W);
  localparam logic [NTAP*COEF_W-1:0] COEF_IDENT = (NTAP*COEF_W)'(1) << (COEF_W * (NTAP/2));

  state_e                      state_q, state_d;
  logic [RI_W-1:0]             ri_q, ri_d, ri_nxt;
  logic [CI_W-1:0]             ci_q, ci_d, ci_nxt;
  logic [3:0]                  shift_q, shift_d;
  logic                        border_q, border_d;
  logic [NTAP-1:0][COEF_W-1:0] coef_q, coef_d;
  logic [NTAP-1:0][PIX_W-1:0]  win_q, win_d;
  logic [PIX_W-1:0]            res_q, res_d, mac_res, pix_in;
  logic [PIX_W-1:0]            lb0_q [IMG_W+1];
  logic [PIX_W-1:0]            lb1_q [IMG_W+1];
  logic [KSIZE-1:0]            row_ok, col_ok;
  logic [NTAP-1:0]             valid;
  logic                        cap_en, advance, pad_pos, last_pos, out_pos;
  logic [ADDR_W-1:0]           src_addr, dst_addr;
  logic                        cs, we;
  logic [ADDR_W-1:0]           addr;
  logic [PIX_W-1:0]            din;

  assign mem.cs   = cs;
  assign mem.we   = we;
  assign mem.addr = addr;
  assign mem.din  = din;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    pad_pos  = (ri_q == RI_LAST) || (ci_q == CI_LAST);
    last_pos = (ri_q == RI_LAST) && (ci_q == CI_LAST);
    out_pos  = (ri_q != '0) && (ci_q != '0);
    if (ci_q == CI_LAST) begin
      ci_nxt = '0;
      ri_nxt = ri_q + RI_W'(1);
    end else begin
      ci_nxt = ci_q + CI_W'(1);
      ri_nxt = ri_q;
    end
    // Window rows/cols are centre-1..centre+1 with centre at (ri-1, ci-1).
    row_ok = {ri_q != RI_LAST, 1'b1, ri_q > RI_W'(1)};
    col_ok = {ci_q != CI_LAST, 1'b1, ci_q > CI_W'(1)};
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        valid[r*KSIZE + c] = row_ok[r] & col_ok[c];
    pix_in   = pad_pos ? '0 : mem.dout;
    src_addr = ADDR_W'(SRC_BASE) + ADDR_W'(ri_q) * ADDR_W'(IMG_W) + ADDR_W'(ci_q);
    dst_addr = ADDR_W'(DST_BASE) + (ADDR_W'(ri_q) - ADDR_W'(1)) * ADDR_W'(IMG_W)
             + ADDR_W'(ci_q) - ADDR_W'(1);
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ri_d     = ri_q;
    ci_d     = ci_q;
    shift_d  = shift_q;
    border_d = border_q;
    cap_en   = 1'b0;
    advance  = 1'b0;
    cs       = 1'b0;
    we       = 1'b0;
    addr     = '0;
    din      = '0;
    finish   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_RD;
        ri_d     = '0;
        ci_d     = '0;
        shift_d  = shift;
        border_d = border_mode;
      end
      S_RD: begin
        cs      = 1'b1;
        addr    = src_addr;
        state_d = S_CAP;
      end
      S_CAP: begin
        cap_en = 1'b1;
        if (out_pos) state_d = S_WR;
        else         advance = 1'b1;
      end
      S_WR: begin
        cs      = 1'b1;
        we      = 1'b1;
        addr    = dst_addr;
        din     = res_q;
        advance = 1'b1;
      end
      S_DONE: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (last_pos) state_d = S_DONE;
      else begin
        ri_d    = ri_nxt;
        ci_d    = ci_nxt;
        state_d = (ri_nxt == RI_LAST || ci_nxt == CI_LAST) ? S_CAP : S_RD;
      end
    end
  end

  always_comb begin
    coef_d = coef_q;
    if (state_q == S_IDLE && h_write && h_idx < IDX_W'(NTAP)) coef_d[h_idx] = h_data;
    win_d = win_q;
    if (cap_en) begin
      for (int r = 0; r < KSIZE; r++) begin
        win_d[r*KSIZE]     = win_q[r*KSIZE + 1];
        win_d[r*KSIZE + 1] = win_q[r*KSIZE + 2];
      end
      win_d[KSIZE-1]   = lb1_q[ci_q];
      win_d[2*KSIZE-1] = lb0_q[ci_q];
      win_d[3*KSIZE-1] = pix_in;
    end
    res_d = cap_en ? mac_res : res_q;
  end

  // The MAC sees the already-shifted window so its result lines up with this position.
  filter2d_mac #(.PIX_W(PIX_W), .COEF_W(COEF_W)) u_mac (
    .pix         (win_d),
    .coef        (coef_q),
    .valid       (valid),
    .shift       (shift_q),
    .border_mode (border_q),
    .result      (mac_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ri_q     <= '0;
      ci_q     <= '0;
      shift_q  <= '0;
      border_q <= 1'b0;
      coef_q   <= COEF_IDENT;
      win_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      ri_q     <= ri_d;
      ci_q     <= ci_d;
      shift_q  <= shift_d;
      border_q <= border_d;
      coef_q   <= coef_d;
      win_q    <= win_d;
      res_q    <= res_d;
    end
  end

  // NOTE: line buffers carry no reset; stale contents only ever reach masked taps.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      lb1_q[ci_q] <= lb0_q[ci_q];
      lb0_q[ci_q] <= pix_in;
    end
  end

endmodule

// File: doc/filter2d_lb.md
Name: filter2d_lb

Overview:
- Parametrised successor to the fixed 256x256 3x3 filter engine.
- Reads an IMG_W x IMG_H image row-major from a single-port buffer and keeps two internal line buffers, so each input pixel is read exactly once.
- Applies a programmable signed 3x3 kernel with rounding shift and saturation, then writes the result back to the same buffer.
- Adds selectable border handling, a runtime shift and a busy flag; sits between the control/coefficient host and mem_single.

Parameters:
- IMG_W, 256, image width in pixels (>=2)
- IMG_H, 256, image height in lines (>=2)
- PIX_W, 8, unsigned pixel width
- COEF_W, 8, signed coefficient width
- ADDR_W, 17, memory address width
- SRC_BASE, 0, input image base address
- DST_BASE, IMG_W*IMG_H, output image base address

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle run request, sampled only in IDLE
- finish  out  1  one-cycle pulse when the last output pixel is written
- busy  out  1  high from the cycle after start until the finish cycle inclusive
- cs  out  1  memory chip select
- we  out  1  memory write enable (1 = write)
- addr  out  ADDR_W  memory address
- din  out  PIX_W  write data to memory
- dout  in  PIX_W  read data from memory, valid 1 cycle after a read
- h_write  in  1  coefficient write strobe
- h_idx  in  4  tap index 0..8, row-major (0 = top-left)
- h_data  in  COEF_W  signed coefficient value
- shift  in  4  right-shift applied after accumulation, sampled at start
- border_mode  in  1  0 = zero padding; 1 = border outputs copy the input pixel; sampled at start

Behaviour:
- Reset state and outputs:
  - finish=0, busy=0, cs=0, we=0, addr=0, din=0, state IDLE.
  - Coefficients reset to identity: tap 4 = 1, all other taps 0.
  - Line buffers are not reset.
- Coefficient writes:
  - Accepted only in IDLE: coef[h_idx] <= h_data.
  - h_idx >= 9 is ignored.
  - h_write while busy is ignored.
- Scan:
  - A position counter (ri, ci) runs over 0..IMG_H x 0..IMG_W inclusive.
  - Positions with ri==IMG_H or ci==IMG_W are pad positions and issue no read.
- FSM states: IDLE, RD, CAP, WR, DONE.
  - IDLE: start=1 goes to RD, with (ri, ci)=(0, 0) and shift/border_mode latched.
  - RD: cs=1, we=0, addr=SRC_BASE+ri*IMG_W+ci; go to CAP.
  - Pad positions skip RD: go from the previous state directly to CAP, with input value 0.
  - CAP: capture p = dout (or 0 on a pad position).
    - Window shifts left; its new right column is {lb1[ci], lb0[ci], p}.
    - Line buffers update: lb1[ci]<=lb0[ci], lb0[ci]<=p.
    - The MAC result is registered.
    - If ri>=1 and ci>=1, go to WR; else advance the position.
  - WR: cs=1, we=1, addr=DST_BASE+(ri-1)*IMG_W+(ci-1), din=registered result; then advance.
  - Advance: ci increments; at ci==IMG_W it wraps to 0 and ri increments. After (IMG_H, IMG_W) go to DONE.
  - DONE: finish=1 for one cycle, cs=0, then IDLE.
- Output centre is (ro, co) = (ri-1, ci-1).
  - A tap (dr, dc) in -1..1 is valid iff 0<=ro+dr<IMG_H and 0<=co+dc<IMG_W.
  - Invalid taps contribute 0 (border_mode=0).
  - With border_mode=1, any output with an invalid tap equals its centre pixel unchanged.
- Arithmetic:
  - Each product is pixel (zero-extended, signed) times coef.
  - The 9-term signed sum has width PIX_W+COEF_W+5.
  - If shift>0, add 1<<(shift-1) before an arithmetic right shift.
  - Saturate to [0, 2^PIX_W-1].
- Timing: finish is high exactly 3*W*H+W+H+1 cycles after the start edge (W=IMG_W, H=IMG_H).
- cs=0 in IDLE, CAP and DONE; the bus never sees read and write in the same cycle.
- start while busy is ignored; start and finish in the same cycle are not possible.
- rst mid-run: return to IDLE within that cycle.
  - cs and we are deasserted and no finish is produced.
  - Coefficients revert to identity; partial output is left in memory.

Decomposition:
- filter2d_pkg holds:
  - state enum;
  - KSIZE=3, NTAP=9, IDX_W=4;
  - sat_pix function (saturate to PIX_W);
  - acc width function.
- Sub-module filter2d_mac: nine window pixels, coefficients, valid mask, shift and border_mode in; saturated pixel out.
  - Purely combinational; the result register lives in the top.

Test Plan:
- IMG 4x4, ramp 0..15, default coefficients, shift 0 -> output equals input; finish at cycle 57 after start, busy high throughout.
- Constant 16, all coefs 1, shift 0, border_mode 0 -> interior 144, edges 96, corners 64.
- Same stimulus with border_mode 1 -> interior 144, all border pixels 16.
- Constant 100, centre coef 4 -> every output 255. Centre coef -1 -> every output 0 (saturation both ends).
- Constant 5, centre coef 3, shift 1 -> every output 8 (rounding). h_write idx 4 = 0 while busy -> result unchanged; h_idx 12 ignored.
- rst asserted at cycle 20 of a run -> cs=0 and busy=0 next cycle, no finish; coefficients are identity again; a new start completes normally.
